// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter with a clear sequencer for r1..r31.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rf_write_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     ctrl_writeEnable,
    output logic [ADDR_W-1:0]        ctrl_writeReg,
    output logic [DATA_W-1:0]        data_writeReg
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [IW-1:0]     gidx;
    logic              found;
    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];

`ifndef RF_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     ptr;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Search order: fixed from 0, or rotating from the slot after the last winner
    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        idx   = 0;
        cand  = '0;
        gidx  = '0;
        found = 1'b0;
        if (!ctrl_reset && state == S_IDLE && !clear_start) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = int'(ptr) + 1 + k;
                if (idx >= NREQ)
                    idx = idx - NREQ;
`endif
                cand = IW'(idx);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found)
            req_ready[gidx] = 1'b1;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state            <= S_IDLE;
            cnt              <= ADDR_W'(1);
            clear_busy       <= 1'b0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr              <= IW'(NREQ - 1);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        state            <= S_CLEAR;
                        clear_busy       <= 1'b1;
                        ctrl_writeEnable <= 1'b0;
                    end else if (found) begin
                        // r0 is hardwired zero: consume the request, suppress the strobe
                        ctrl_writeEnable <= (addr_a[gidx] != '0);
                        ctrl_writeReg    <= addr_a[gidx];
                        data_writeReg    <= data_a[gidx];
`ifndef RF_ARB_FIXED_PRIO_EN
                        ptr              <= gidx;
`endif
                    end else begin
                        ctrl_writeEnable <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= cnt;
                    data_writeReg    <= '0;
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state      <= S_IDLE;
                        clear_busy <= 1'b0;
                        cnt        <= ADDR_W'(1);
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter (NREQ=2).
// Expected values are hand-derived; fixed-priority build selected by RF_ARB_FIXED_PRIO_EN.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        clear_start;
    logic        clear_busy;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.NREQ(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        #1 ctrl_reset = 1'b1;
        #1 ctrl_reset = 1'b0;
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0,
                           input logic [31:0] d0, input logic [4:0] a1,
                           input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
    endtask

    logic [1:0] g_exp [4];
    logic [4:0] a_exp [4];

    initial begin
`ifdef RF_ARB_FIXED_PRIO_EN
        g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
        a_exp = '{5'd3, 5'd3, 5'd3, 5'd3};
`else
        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        a_exp = '{5'd3, 5'd7, 5'd3, 5'd7};
`endif
        ctrl_reset  = 1'b1;
        clear_start = 1'b0;
        req_valid   = 2'b11;
        req_addr    = {5'd7, 5'd3};
        req_data    = 64'h1;
        #12;
        check("rst_ready", req_ready, 2'b00);
        check("rst_we", ctrl_writeEnable, 1'b0);
        check("rst_reg", ctrl_writeReg, 5'd0);
        check("rst_data", data_writeReg, 32'd0);
        check("rst_busy", clear_busy, 1'b0);
        ctrl_reset = 1'b0;
        step();

        // single write
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        check("t1_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("t1_we", ctrl_writeEnable, 1'b1);
        check("t1_reg", ctrl_writeReg, 5'd5);
        check("t1_data", data_writeReg, 32'hDEADBEEF);

        // contention from reset pointer
        pulse_reset();
        set_req(2'b11, 5'd3, 32'hAAAA0003, 5'd7, 32'hBBBB0007);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_ready%0d", i), req_ready, g_exp[i]);
            step();
            check($sformatf("t2_we%0d", i), ctrl_writeEnable, 1'b1);
            check($sformatf("t2_reg%0d", i), ctrl_writeReg, a_exp[i]);
        end

        // r0 request consumed without strobe
        set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'h12345678);
        check("t3_ready", req_ready, 2'b10);
        step();
        check("t3_we", ctrl_writeEnable, 1'b0);
        set_req(2'b11, 5'd9, 32'h00000009, 5'd10, 32'h0000000A);
        check("t3_ready2", req_ready, 2'b01);
        step();
        check("t3_we2", ctrl_writeEnable, 1'b1);
        check("t3_reg2", ctrl_writeReg, 5'd9);
        set_req(2'b00, 5'd1, 32'h1, 5'd2, 32'h2);
        check("idle_ready", req_ready, 2'b00);
        step();
        check("idle_we", ctrl_writeEnable, 1'b0);
        check("idle_reg", ctrl_writeReg, 5'd9);
        check("idle_data", data_writeReg, 32'h9);

        // leave ptr at 1, then clear with both requests pending
        set_req(2'b10, 5'd1, 32'h1, 5'd4, 32'h44);
        check("t4_pre", req_ready, 2'b10);
        step();
        set_req(2'b11, 5'd6, 32'h66, 5'd8, 32'h88);
        clear_start = 1'b1;
        #1;
        check("t4_start_ready", req_ready, 2'b00);
        step();
        clear_start = 1'b0;
        check("t4_busy0", clear_busy, 1'b1);
        check("t4_we0", ctrl_writeEnable, 1'b0);
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) clear_start = 1'b1;
            #1;
            check($sformatf("c_ready%0d", i), req_ready, 2'b00);
            check($sformatf("c_busy%0d", i), clear_busy, 1'b1);
            step();
            clear_start = 1'b0;
            check($sformatf("c_we%0d", i), ctrl_writeEnable, 1'b1);
            check($sformatf("c_reg%0d", i), ctrl_writeReg, i[4:0]);
            check($sformatf("c_data%0d", i), data_writeReg, 32'd0);
        end
        check("t4_busy_end", clear_busy, 1'b0);
        check("t4_first_grant", req_ready, 2'b01);
        step();
        check("t4_after_reg", ctrl_writeReg, 5'd6);
        check("t4_after_data", data_writeReg, 32'h66);

        // reset in the middle of a clear
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 1; i < 12; i++) step();
        check("t5_mid_reg", ctrl_writeReg, 5'd11);
        ctrl_reset = 1'b1;
        #1;
        check("t5_rst_we", ctrl_writeEnable, 1'b0);
        check("t5_rst_reg", ctrl_writeReg, 5'd0);
        check("t5_rst_data", data_writeReg, 32'd0);
        check("t5_rst_busy", clear_busy, 1'b0);
        ctrl_reset = 1'b0;
        step();
        step();
        check("t5_no_clear_we", ctrl_writeEnable, 1'b0);
        check("t5_no_clear_busy", clear_busy, 1'b0);
        set_req(2'b10, 5'd0, 32'h0, 5'd12, 32'hCAFEF00D);
        check("t5_ready", req_ready, 2'b10);
        step();
        check("t5_we", ctrl_writeEnable, 1'b1);
        check("t5_reg", ctrl_writeReg, 5'd12);
        check("t5_data", data_writeReg, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (5-bit write select feeding the 5-to-32 write decoder, plus 32-bit write data) among NREQ writeback requesters, using round-robin arbitration.
- Also contains a clear sequencer that walks registers 1..31 and writes zero to each.
- Sits between the writeback stages and the register file; drives ctrl_writeEnable, ctrl_writeReg and data_writeReg from flops.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
DATA_W, 32, write data width
ADDR_W, 5, register select width (fixed to 5 for 32 registers)

Ports:
clock  in  1  single clock, rising edge
ctrl_reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  requester i has a pending write
req_addr  in  NREQ*ADDR_W  destination of requester i; slice i = [i*5+4:i*5]
req_data  in  NREQ*DATA_W  write data of requester i; slice i = [i*32+31:i*32]
req_ready  out  NREQ  one-hot grant, combinational; transfer when valid&ready
clear_start  in  1  one-cycle pulse; requests a full clear
clear_busy  out  1  high while the clear sequence runs
ctrl_writeEnable  out  1  register file write strobe, registered
ctrl_writeReg  out  ADDR_W  register file write select, registered
data_writeReg  out  DATA_W  register file write data, registered

Behaviour:
- Reset (asynchronous): state=IDLE, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, clear_busy=0, clear counter=1, rr pointer=NREQ-1 (requester 0 wins first). req_ready=0 while ctrl_reset is high.
- States are IDLE and CLEAR.
- IDLE arbitration:
  - Search starts at index (ptr+1) mod NREQ and wraps; the first index with req_valid=1 is granted. req_ready has exactly that bit set.
  - On grant: ptr <= granted index. Next edge: ctrl_writeEnable=1, ctrl_writeReg=req_addr[g], data_writeReg=req_data[g].
  - Latency is 1 cycle. At most one grant per cycle, so throughput is one write per cycle.
- No valid requests: ctrl_writeEnable=0 next cycle; ctrl_writeReg and data_writeReg hold their values.
- Address 0: the request is granted and consumed (ready=1, ptr updates) but ctrl_writeEnable=0. r0 is never written.
- clear_start in IDLE:
  - Takes priority over requests. No grant that cycle; req_ready=0.
  - Next state CLEAR; clear_busy=1 from the next edge.
- CLEAR:
  - Each cycle: ctrl_writeEnable=1, ctrl_writeReg=counter, data_writeReg=0; counter increments.
  - Sequence is 1,2,...,31 (31 write cycles).
  - After the write of 31: state=IDLE, clear_busy=0, counter=1. Arbitration resumes on the first IDLE cycle.
  - req_ready=0 throughout CLEAR. Requesters hold valid; nothing is dropped. clear_start during CLEAR is ignored; it does not restart the sequence.
- ctrl_reset mid-clear or mid-write: immediate return to reset values. A partial clear is abandoned and not resumed.
- ptr does not change during CLEAR.

Optional Feature:
- Macro RF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_valid wins; ptr is removed.
- Undefined: the round-robin scheme described above.
- Clear, address-0 and latency rules are identical in both builds.

Test Plan:
- Reset, then req_valid=2'b01, req_addr[0]=5, req_data[0]=0xDEADBEEF -> req_ready=2'b01 same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF.
- Both valid for 4 cycles, addr0=3, addr1=7 -> grants 01,10,01,10; writes to 3,7,3,7 on consecutive cycles. With RF_ARB_FIXED_PRIO_EN: grants 01,01,01,01.
- req_valid=2'b10, req_addr[1]=0 -> req_ready=2'b10; next cycle ctrl_writeEnable=0; a following req0 then wins (ptr=1).
- clear_start pulse with both requests valid:
  - clear_busy=1 for 31 cycles, writes to 1..31 with data 0, req_ready=0 throughout.
  - First IDLE cycle grants requester 0 (ptr unchanged).
  - A second clear_start at clear cycle 10 has no effect.
- Assert ctrl_reset at clear cycle 12 -> all outputs 0 asynchronously. After release, no further clear writes; a req1 write proceeds normally.
